// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage: issues imem word reads under a credit limit and
// buffers returned words, tagged with their PC, in an in-order queue for decode.
module inst_fetch_unit #(
    parameter int          IQ_DEPTH  = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] pc_i,
    input  logic        pc_valid_i,
    input  logic        redirect_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        fetch_hold_o,
    output logic [29:0] pc_o,
    output logic [31:0] inst32_o,
    output logic        inst_valid_o
);
    localparam int AW = $clog2(IQ_DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [29:0] iq_pc_mem   [IQ_DEPTH];
    logic [31:0] iq_inst_mem [IQ_DEPTH];
    logic [29:0] pend_pc_mem [MAX_OUTST];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [PW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
    logic [CW-1:0] out_q, out_d, drop_q, drop_d;
    logic [29:0]   last_pc_q, last_pc_d;

    logic credit, grant, empty, rsp, rsp_keep, rsp_drop, pop;

    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // A request is only allowed if its response is guaranteed a queue slot.
    assign credit = (int'(out_q) < MAX_OUTST) && (int'(occ_q) + int'(out_q) < IQ_DEPTH);

    assign imem_req_o   = pc_valid_i & credit & ~redirect_i;
    assign imem_addr_o  = {pc_i, 2'b00};
    assign grant        = imem_req_o & imem_gnt_i;
    assign fetch_hold_o = pc_valid_i & ~grant;

    assign empty        = (occ_q == '0);
    assign inst_valid_o = ~empty;
    assign pc_o         = empty ? last_pc_q : iq_pc_mem[head_q];
    assign inst32_o     = empty ? NOP_INST : iq_inst_mem[head_q];

    // Stray responses (nothing outstanding, e.g. abandoned by reset) are ignored.
    assign rsp      = imem_rvalid_i & (out_q != '0);
    assign rsp_drop = rsp & (drop_q != '0);
    assign rsp_keep = rsp & (drop_q == '0);
    assign pop      = inst_valid_o & ~stall_i;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        occ_d     = occ_q;
        pend_rd_d = pend_rd_q;
        pend_wr_d = pend_wr_q;
        out_d     = out_q;
        drop_d    = drop_q;
        last_pc_d = pc_o;
        if (redirect_i) begin
            head_d    = '0;
            tail_d    = '0;
            occ_d     = '0;
            pend_rd_d = '0;
            pend_wr_d = '0;
            out_d     = out_q - CW'(rsp);
            drop_d    = out_q - CW'(rsp);
        end else begin
            out_d = out_q + CW'(grant) - CW'(rsp);
            if (rsp_drop) drop_d = drop_q - 1'b1;
            if (grant) pend_wr_d = pend_inc(pend_wr_q);
            if (rsp_keep) begin
                pend_rd_d = pend_inc(pend_rd_q);
                tail_d    = tail_q + 1'b1;
            end
            if (pop) head_d = head_q + 1'b1;
            occ_d = occ_q + OW'(rsp_keep) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            occ_q     <= '0;
            pend_rd_q <= '0;
            pend_wr_q <= '0;
            out_q     <= '0;
            drop_q    <= '0;
            last_pc_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            occ_q     <= occ_d;
            pend_rd_q <= pend_rd_d;
            pend_wr_q <= pend_wr_d;
            out_q     <= out_d;
            drop_q    <= drop_d;
            last_pc_q <= last_pc_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (grant) pend_pc_mem[pend_wr_q] <= pc_i;
        if (rsp_keep && !redirect_i) begin
            iq_pc_mem[tail_q]   <= pend_pc_mem[pend_rd_q];
            iq_inst_mem[tail_q] <= imem_rdata_i;
        end
    end

    // The first cycle out of reset may still see a response abandoned by that reset.
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
        (imem_rvalid_i && out_q == '0) |-> !$past(rst));
    a_out_bound: assert property (@(posedge clk) disable iff (!rst)
        (out_q <= CW'(MAX_OUTST)) && (drop_q <= out_q));
endmodule
